// File: rtl/y86_fde_core_if.sv
// y86_fde_core_if: PC, program-load, write-back and decoded-result bundle for the Y86-64 front half.
interface y86_fde_core_if;
    logic [63:0] PC;
    logic        imem_we;
    logic [63:0] imem_addr;
    logic [7:0]  imem_wdata;
    logic        wbE_en;
    logic [3:0]  dstE;
    logic [63:0] wbE_data;
    logic        wbM_en;
    logic [3:0]  dstM;
    logic [63:0] wbM_data;
    logic [3:0]  icode, ifun, rA, rB;
    logic        need_regids, need_valC;
    logic [63:0] valC, valP;
    logic        instr_valid, imem_error, hlt;
    logic [63:0] valA, valB, valE;
    logic        Cnd;
    logic        zero_flag, sign_flag, overflow_flag;
    modport slave (
        input  PC, imem_we, imem_addr, imem_wdata, wbE_en, dstE, wbE_data, wbM_en, dstM, wbM_data,
        output icode, ifun, rA, rB, need_regids, need_valC, valC, valP, instr_valid, imem_error, hlt,
        output valA, valB, valE, Cnd, zero_flag, sign_flag, overflow_flag
    );
    modport master (
        output PC, imem_we, imem_addr, imem_wdata, wbE_en, dstE, wbE_data, wbM_en, dstM, wbM_data,
        input  icode, ifun, rA, rB, need_regids, need_valC, valC, valP, instr_valid, imem_error, hlt,
        input  valA, valB, valE, Cnd, zero_flag, sign_flag, overflow_flag
    );
endinterface

// File: rtl/y86_fde_core.sv
// y86_fde_core: Y86-64 SEQ fetch/decode/execute with register file, condition codes and instruction memory.
module y86_fde_core #(
    parameter int IMEM_BYTES = 1024
) (
    input logic clk,
    input logic reset,
    y86_fde_core_if.slave bus
);
    localparam int AW = $clog2(IMEM_BYTES);
    logic [7:0]  imem_q [IMEM_BYTES];
    logic [63:0] regs_q [15];
    logic        zf_q, sf_q, of_q, zf_d, sf_d, of_d;
    logic [7:0]  b [10];
    logic [3:0]  ic_r, fn_r, len, icode, ifun, src_a, src_b;
    logic        regs_r, valc_r, err, valid, cond, sxo;
    logic [64:0] last;
    logic [63:0] valc_r_w, val_a, val_b, val_c, val_e;

    function automatic logic [7:0] rd(input logic [63:0] a);
        return a < 64'(IMEM_BYTES) ? imem_q[a[AW-1:0]] : 8'h00;
    endfunction

    for (genvar k = 0; k < 10; k++) begin : g_byte
        assign b[k] = rd(bus.PC + 64'(k));
    end

    assign {ic_r, fn_r} = b[0];
    assign regs_r   = ic_r inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    assign valc_r   = ic_r inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
    assign len      = 4'd1 + {3'b000, regs_r} + {valc_r, 3'b000};
    // 65-bit so a PC near 2^64 cannot wrap back into range
    assign last     = {1'b0, bus.PC} + 65'(len) - 65'd1;
    assign err      = last >= 65'(IMEM_BYTES);
    assign valc_r_w = regs_r ? {b[9], b[8], b[7], b[6], b[5], b[4], b[3], b[2]}
                             : {b[8], b[7], b[6], b[5], b[4], b[3], b[2], b[1]};

    assign icode = err ? 4'h1 : ic_r;
    assign ifun  = err ? 4'h0 : fn_r;
    assign val_c = (!err && valc_r) ? valc_r_w : 64'd0;
    assign valid = icode <= 4'hB && ((icode == 4'h2 || icode == 4'h7) ? ifun <= 4'h6
                 : icode == 4'h6 ? ifun <= 4'h3 : ifun == 4'h0);

    assign bus.icode       = icode;
    assign bus.ifun        = ifun;
    assign bus.rA          = (err || !regs_r) ? 4'hF : b[1][7:4];
    assign bus.rB          = (err || !regs_r) ? 4'hF : b[1][3:0];
    assign bus.need_regids = !err && regs_r;
    assign bus.need_valC   = !err && valc_r;
    assign bus.valC        = val_c;
    assign bus.valP        = err ? 64'd0 : bus.PC + 64'(len);
    assign bus.instr_valid = valid;
    assign bus.imem_error  = err;
    assign bus.hlt         = icode == 4'h0 && !err;

    assign src_a = icode inside {4'h2, 4'h4, 4'h6, 4'hA} ? bus.rA : icode inside {4'h9, 4'hB} ? 4'h4 : 4'hF;
    assign src_b = icode inside {4'h4, 4'h5, 4'h6} ? bus.rB : icode inside {4'h8, 4'h9, 4'hA, 4'hB} ? 4'h4 : 4'hF;
    assign val_a = src_a == 4'hF ? 64'd0 : regs_q[src_a];
    assign val_b = src_b == 4'hF ? 64'd0 : regs_q[src_b];
    assign bus.valA = val_a;
    assign bus.valB = val_b;

    always_comb begin
        val_e = 64'd0;
        of_d  = 1'b0;
        case (icode)
            4'h2: val_e = val_a;
            4'h3: val_e = val_c;
            4'h4, 4'h5: val_e = val_b + val_c;
            4'h6: begin
                val_e = ifun == 4'h0 ? val_b + val_a : ifun == 4'h1 ? val_b - val_a
                      : ifun == 4'h2 ? val_b & val_a : ifun == 4'h3 ? val_b ^ val_a : 64'd0;
                of_d  = ifun == 4'h0 ? (val_a[63] == val_b[63]) && (val_e[63] != val_a[63])
                      : ifun == 4'h1 ? (val_b[63] != val_a[63]) && (val_e[63] != val_b[63]) : 1'b0;
            end
            4'h8, 4'hA: val_e = val_b - 64'd8;
            4'h9, 4'hB: val_e = val_b + 64'd8;
            default: val_e = 64'd0;
        endcase
    end

    assign zf_d    = val_e == 64'd0;
    assign sf_d    = val_e[63];
    assign bus.valE = val_e;

    assign sxo  = sf_q ^ of_q;
    assign cond = ifun == 4'h0 ? 1'b1 : ifun == 4'h1 ? sxo | zf_q : ifun == 4'h2 ? sxo
                : ifun == 4'h3 ? zf_q : ifun == 4'h4 ? ~zf_q : ifun == 4'h5 ? ~sxo
                : ifun == 4'h6 ? ~sxo & ~zf_q : 1'b0;
    assign bus.Cnd           = (icode == 4'h2 || icode == 4'h7) && cond;
    assign bus.zero_flag     = zf_q;
    assign bus.sign_flag     = sf_q;
    assign bus.overflow_flag = of_q;

    always_ff @(posedge clk) begin
        if (bus.imem_we && bus.imem_addr < 64'(IMEM_BYTES))
            imem_q[bus.imem_addr[AW-1:0]] <= bus.imem_wdata;
    end

    // M is written after E so it wins when both target the same register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 15; i++) regs_q[i] <= 64'd0;
        end else begin
            if (bus.wbE_en && bus.dstE != 4'hF) regs_q[bus.dstE] <= bus.wbE_data;
            if (bus.wbM_en && bus.dstM != 4'hF) regs_q[bus.dstM] <= bus.wbM_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zf_q <= 1'b1;
            sf_q <= 1'b0;
            of_q <= 1'b0;
        end else if (icode == 4'h6 && valid && !err) begin
            zf_q <= zf_d;
            sf_q <= sf_d;
            of_q <= of_d;
        end
    end
endmodule

// File: tb/tb_y86_fde_core.sv
// tb_y86_fde_core: directed fetch/decode/execute vectors plus condition-code, write-port and reset sequences.
module tb_y86_fde_core;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    y86_fde_core_if bus();
    y86_fde_core #(.IMEM_BYTES(1024)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [3:0]  ic, fn, ra, rb;
        logic [63:0] vc, vp, ve;
        logic        nr, nv, ok, er, h, cn, ce, cv;
    } vec_t;
    vec_t tv [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic put(input logic [63:0] a, input logic [7:0] d);
        bus.imem_we = 1'b1;
        bus.imem_addr = a;
        bus.imem_wdata = d;
        @(posedge clk);
        #1;
        bus.imem_we = 1'b0;
    endtask

    task automatic ld(input logic [63:0] a, input logic [79:0] v, input int n);
        for (int i = 0; i < n; i++) put(a + 64'(i), v[79-8*i -: 8]);
    endtask

    task automatic wr(input logic e_en, input logic [3:0] de, input logic [63:0] ed,
                      input logic m_en, input logic [3:0] dm, input logic [63:0] md);
        bus.wbE_en = e_en; bus.dstE = de; bus.wbE_data = ed;
        bus.wbM_en = m_en; bus.dstM = dm; bus.wbM_data = md;
        @(posedge clk);
        #1;
        bus.wbE_en = 1'b0;
        bus.wbM_en = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.PC = 64'd0;
        bus.imem_we = 1'b0; bus.imem_addr = 64'd0; bus.imem_wdata = 8'h00;
        bus.wbE_en = 1'b0; bus.dstE = 4'hF; bus.wbE_data = 64'd0;
        bus.wbM_en = 1'b0; bus.dstM = 4'hF; bus.wbM_data = 64'd0;
        #12;
        chk("reset zf", bus.zero_flag, 1);
        chk("reset sf", bus.sign_flag, 0);
        chk("reset of", bus.overflow_flag, 0);
        reset = 1'b0;

        ld(0,    80'h30F3_0A00_0000_0000_0000, 10);
        ld(10,   80'h6103_0000_0000_0000_0000, 2);
        ld(12,   80'h7340_0000_0000_0000_0000, 9);
        ld(21,   80'h8000_0100_0000_0000_0000, 9);
        ld(30,   80'h9000_0000_0000_0000_0000, 1);
        ld(31,   80'h6003_0000_0000_0000_0000, 2);
        ld(33,   80'h2203_0000_0000_0000_0000, 2);
        ld(35,   80'hC000_0000_0000_0000_0000, 1);
        ld(36,   80'h0000_0000_0000_0000_0000, 1);
        ld(37,   80'h5015_0800_0000_0000_0000, 10);
        ld(47,   80'h6F03_0000_0000_0000_0000, 2);
        ld(49,   80'h2013_0000_0000_0000_0000, 2);
        ld(1019, 80'h30F3_0500_0000_0000_0000, 10);

        //         pc   ic fn ra rb  valC  valP  valE                   nr nv ok er h cn ce cv
        tv.push_back('{0,    3, 0,15, 3, 10,    10,   10,                    1,1,1,0,0,0,1,1});
        tv.push_back('{10,   6, 1, 0, 3, 0,     12,   0,                     1,0,1,0,0,0,1,1});
        tv.push_back('{12,   7, 3,15,15, 'h40,  21,   0,                     0,1,1,0,0,1,1,1});
        tv.push_back('{21,   8, 0,15,15, 'h100, 30,   64'hFFFFFFFFFFFFFFF8,  0,1,1,0,0,0,1,1});
        tv.push_back('{30,   9, 0,15,15, 0,     31,   8,                     0,0,1,0,0,0,1,1});
        tv.push_back('{31,   6, 0, 0, 3, 0,     33,   0,                     1,0,1,0,0,0,1,1});
        tv.push_back('{33,   2, 2, 0, 3, 0,     35,   0,                     1,0,1,0,0,0,1,1});
        tv.push_back('{35,  12, 0,15,15, 0,     36,   0,                     0,0,0,0,0,0,1,1});
        tv.push_back('{36,   0, 0,15,15, 0,     37,   0,                     0,0,1,0,1,0,1,1});
        tv.push_back('{37,   5, 0, 1, 5, 8,     47,   8,                     1,1,1,0,0,0,1,1});
        tv.push_back('{47,   6,15, 0, 3, 0,     49,   0,                     1,0,0,0,0,0,0,1});
        tv.push_back('{49,   2, 0, 1, 3, 0,     51,   0,                     1,0,1,0,0,1,1,1});
        tv.push_back('{1019, 1, 0,15,15, 0,     0,    0,                     0,0,0,1,0,0,1,0});
        tv.push_back('{1022, 0, 0,15,15, 0,     1023, 0,                     0,0,1,0,1,0,1,1});
        tv.push_back('{1023, 0, 0,15,15, 0,     1024, 0,                     0,0,1,0,1,0,1,1});
        tv.push_back('{1024, 1, 0,15,15, 0,     0,    0,                     0,0,0,1,0,0,1,0});
        tv.push_back('{64'hFFFFFFFFFFFFFFFF, 1, 0,15,15, 0, 0, 0,            0,0,0,1,0,0,1,0});

        foreach (tv[i]) begin
            bus.PC = tv[i].pc;
            #1;
            chk($sformatf("v%0d icode", i), bus.icode, tv[i].ic);
            chk($sformatf("v%0d ifun", i), bus.ifun, tv[i].fn);
            chk($sformatf("v%0d rA", i), bus.rA, tv[i].ra);
            chk($sformatf("v%0d rB", i), bus.rB, tv[i].rb);
            chk($sformatf("v%0d valC", i), bus.valC, tv[i].vc);
            chk($sformatf("v%0d need_regids", i), bus.need_regids, tv[i].nr);
            chk($sformatf("v%0d need_valC", i), bus.need_valC, tv[i].nv);
            chk($sformatf("v%0d imem_error", i), bus.imem_error, tv[i].er);
            chk($sformatf("v%0d hlt", i), bus.hlt, tv[i].h);
            chk($sformatf("v%0d Cnd", i), bus.Cnd, tv[i].cn);
            if (tv[i].cv) chk($sformatf("v%0d valP", i), bus.valP, tv[i].vp);
            if (tv[i].cv) chk($sformatf("v%0d instr_valid", i), bus.instr_valid, tv[i].ok);
            if (tv[i].ce) chk($sformatf("v%0d valE", i), bus.valE, tv[i].ve);
        end

        bus.PC = 64'd0;
        wr(1, 4'h0, 64'd5, 1, 4'h3, 64'd5);
        bus.PC = 64'd31; #1;
        chk("addq valA", bus.valA, 5);
        chk("addq valB", bus.valB, 5);
        chk("addq valE", bus.valE, 10);
        tick();
        chk("addq zf", bus.zero_flag, 0);
        bus.PC = 64'd10; #1;
        chk("subq valE", bus.valE, 0);
        tick();
        chk("subq zf", bus.zero_flag, 1);
        chk("subq sf", bus.sign_flag, 0);
        chk("subq of", bus.overflow_flag, 0);
        bus.PC = 64'd12; #1;
        chk("je Cnd", bus.Cnd, 1);
        chk("je valP", bus.valP, 21);

        bus.PC = 64'd0;
        wr(1, 4'h4, 64'd64, 0, 4'hF, 64'd0);
        bus.PC = 64'd21; #1;
        chk("call valB", bus.valB, 64);
        chk("call valE", bus.valE, 56);
        bus.PC = 64'd30; #1;
        chk("ret valA", bus.valA, 64);
        chk("ret valE", bus.valE, 72);

        bus.PC = 64'd0;
        wr(1, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 1, 4'h3, 64'd1);
        bus.PC = 64'd31; #1;
        chk("ovf valE", bus.valE, 64'h8000_0000_0000_0000);
        tick();
        chk("ovf sf", bus.sign_flag, 1);
        chk("ovf of", bus.overflow_flag, 1);
        chk("ovf zf", bus.zero_flag, 0);
        bus.PC = 64'd33; #1;
        chk("cmovl Cnd", bus.Cnd, 0);

        bus.PC = 64'd49;
        wr(1, 4'h1, 64'h1111, 1, 4'h1, 64'h2222);
        chk("rcx M wins", bus.valA, 64'h2222);
        chk("rrmovq valE", bus.valE, 64'h2222);

        #2;
        reset = 1'b1;
        #1;
        chk("rst rcx", bus.valA, 0);
        chk("rst zf", bus.zero_flag, 1);
        chk("rst sf", bus.sign_flag, 0);
        chk("rst of", bus.overflow_flag, 0);
        bus.PC = 64'd0; #1;
        chk("rst imem kept", bus.icode, 3);
        chk("rst valE live", bus.valE, 10);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/y86_fde_core.md
Name: y86_fde_core

Overview:
- Front half of the Y86-64 single-cycle (SEQ) processor: fetch, decode and execute stages plus the register file, the condition codes and the instruction memory.
- Given the PC, the block combinationally produces the decoded fields, the operands, the ALU result and the branch/move condition.
- The downstream memory, write-back and PC-update stages consume these outputs; write-back returns results through the register write ports.

Parameters:
- IMEM_BYTES, 1024, instruction memory size in bytes (byte addressed).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- PC  in  64  current instruction address.
- imem_we  in  1  program-load byte write enable.
- imem_addr  in  64  program-load byte address.
- imem_wdata  in  8  program-load byte.
- wbE_en  in  1  register write enable, E port.
- dstE  in  4  register write address, E port.
- wbE_data  in  64  register write data, E port.
- wbM_en  in  1  register write enable, M port.
- dstM  in  4  register write address, M port.
- wbM_data  in  64  register write data, M port.
- icode, ifun, rA, rB  out  4 each  fetched instruction fields.
- need_regids, need_valC  out  1 each  instruction-format flags.
- valC  out  64  constant word.
- valP  out  64  fall-through PC.
- instr_valid  out  1  legal icode/ifun.
- imem_error  out  1  fetch out of range.
- hlt  out  1  current instruction is halt.
- valA, valB  out  64  register operands.
- valE  out  64  ALU result.
- Cnd  out  1  condition result.
- zero_flag, sign_flag, overflow_flag  out  1 each  current condition codes.

Behaviour:
- Fetch (combinational from PC):
  - byte0 = {icode[7:4], ifun[3:0]}; icode and ifun are taken from byte0.
  - need_regids for icode 2,3,4,5,6,A,B. When set, byte1 = {rA, rB}; otherwise rA = rB = F.
  - need_valC for icode 3,4,5,7,8. valC is 8 bytes little-endian, starting at PC+2 when need_regids is set, else PC+1. valC = 0 when not needed.
  - valP = PC + 1 + need_regids + 8*need_valC. Lengths: halt/nop/ret 1; rrmovq/OPq/push/pop 2; jXX/call 9; irmovq/rmmovq/mrmovq 10.
- Validity and errors:
  - instr_valid = 0 when any of: icode > B; ifun != 0 for icode 0,1,3,4,5,8,9,A,B; ifun > 6 for icode 2 or 7; ifun > 3 for icode 6.
  - imem_error = 1 when PC + length - 1 >= IMEM_BYTES. When imem_error is set, icode is forced to 1 (nop) and all other fetched fields are zero, except rA = rB = F.
  - hlt = (icode == 0) and not imem_error.
- Decode:
  - srcA = rA for icode 2,4,6,A; 4 (%rsp) for icode 9,B; else F.
  - srcB = rB for icode 4,5,6; 4 for icode 8,9,A,B; else F.
  - Register file: 15 x 64-bit registers. Read of index F returns 0. Reads are combinational and see the pre-edge contents.
- Execute:
  - icode 2: valE = valA. icode 3: valE = valC. icode 4,5: valE = valB + valC.
  - icode 6: valE = valB OP valA, where ifun 0 add, 1 sub (valB - valA), 2 and, 3 xor.
  - icode 8,A: valE = valB - 8. icode 9,B: valE = valB + 8. All other icodes: valE = 0.
  - All arithmetic is 64-bit, wrap-around.
- Condition (ifun over ZF/SF/OF):
  - 0 always 1; 1 le (SF^OF)|ZF; 2 l SF^OF; 3 e ZF; 4 ne ~ZF; 5 ge ~(SF^OF); 6 g ~(SF^OF)&~ZF.
  - Cnd is evaluated for icode 2 and 7; it is 0 for all other icodes.
- Condition codes:
  - Updated on the rising clk only when icode == 6 and instr_valid and not imem_error.
  - ZF = (valE == 0); SF = valE[63].
  - OF: add, (a[63]==b[63]) && (valE[63]!=a[63]); sub, (valB[63]!=valA[63]) && (valE[63]!=valB[63]); and/xor, 0.
  - Cnd uses the pre-edge flags.
- Register writes (rising clk):
  - E port writes when wbE_en and dstE != F; M port writes when wbM_en and dstM != F.
  - If both ports target the same register, the M port wins.
- Instruction memory: byte write on the rising clk when imem_we and imem_addr < IMEM_BYTES. Contents are not cleared by reset.
- Reset (async): all registers cleared to 0; ZF = 1, SF = 0, OF = 0. The combinational paths remain live during reset.

Test Plan:
- Load 30 F3 0A 00 00 00 00 00 00 00 (irmovq $10,%rbx) at PC 0 -> icode 3, rB 3, rA F, valC 10, valP 10, valE 10, instr_valid 1.
- With %rax = 5 and %rbx = 5 preloaded via the ports, execute 61 03 (subq) and clock -> valE 0, ZF 1, SF 0, OF 0. Then 73 with an 8-byte destination (je) -> Cnd 1, valP = PC + 9.
- %rsp = 64: 80 call -> valB 64, valE 56. 90 ret -> valA 64, valE 72.
- Overflow: %rax = 0x7FFF_FFFF_FFFF_FFFF, %rbx = 1, 60 03 (addq) -> valE 0x8000_0000_0000_0000, SF 1, OF 1. A following 22 (cmovl) -> Cnd 0.
- Byte 0xC0 -> instr_valid 0. Byte 0x00 -> hlt 1. A 10-byte instruction placed at IMEM_BYTES - 5 -> imem_error 1.
- Assert reset mid-run -> registers read 0, ZF 1, SF 0, OF 0 immediately. Simultaneous E and M writes to %rcx -> the M data is stored.
